gf180mcu_osu_sc_gp12t3v3__clkdiv_prog: RTL and testbench



---
 rtl/gf180mcu_osu_sc_gp12t3v3__clkdiv_prog.sv | 132 +++++++++++++
 tb/tb_gf180mcu_osu_sc_gp12t3v3__clkdiv_prog.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_osu_sc_gp12t3v3__clkdiv_prog.sv
// Programmable glitch-free clock divider: Y = CLK / R with R changed via REQ/ACK on period boundaries.
// Latency: Y rises one CLK edge after EN is sampled in IDLE; a new ratio applies from its ACK edge onward.
// Backpressure: REQ is held (DIV stable) until ACK, which fires only on a period boundary. EN=0 finishes the current period.
// Optional: define GF180_CLKDIV_PULSE_EN to add the PULSE output (one-cycle strobe on each Y rising edge).
module gf180mcu_osu_sc_gp12t3v3__clkdiv_prog #(
  parameter int WIDTH       = 4,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             EN,
  input  logic [WIDTH-1:0] DIV,
  input  logic             REQ,
  output logic             ACK,
  output logic             BUSY,
  output logic             Y
`ifdef GF180_CLKDIV_PULSE_EN
  ,
  output logic             PULSE
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] DEF_R   = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] MIN_R   = WIDTH'(2);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH:0]   ONE_EXT = (WIDTH+1)'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             y_q, y_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] div_clamped;
  logic [WIDTH-1:0] cnt_step;
  logic [WIDTH:0]   hi_len;
  logic             wrap;
  logic             boundary;
  logic             capture;

  // Ratio clamp, wrap detect and the period boundary where a new ratio may be taken.
  always_comb begin
    div_clamped = (DIV < MIN_R) ? MIN_R : DIV;
    wrap        = (cnt_q == (r_q - ONE));
    boundary    = (state_q == ST_IDLE) || wrap;
    capture     = REQ && boundary;
    cnt_step    = wrap ? '0 : (cnt_q + ONE);
  end

  // Next-state, counter, ratio and registered output levels.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = capture ? div_clamped : r_q;
    ack_d   = capture;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (EN) state_d = ST_RUN;
      end
      ST_RUN: begin
        cnt_d = cnt_step;
        if (!EN) state_d = ST_STOP;
      end
      ST_STOP: begin
        cnt_d = cnt_step;
        if (EN) begin
          state_d = ST_RUN;
        end else if (wrap) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    // High phase length uses the ratio governing the period being entered; one extra bit avoids overflow at R=2^WIDTH-1.
    hi_len = ({1'b0, r_d} + ONE_EXT) >> 1;
    y_d    = (state_d != ST_IDLE) && ({1'b0, cnt_d} < hi_len);
    busy_d = (state_d != ST_IDLE);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RN) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      r_q     <= DEF_R;
      y_q     <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      y_q     <= y_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign Y    = y_q;
  assign ACK  = ack_q;
  assign BUSY = busy_q;

`ifdef GF180_CLKDIV_PULSE_EN
  logic pulse_q, pulse_d;

  // Strobe aligned with the cycle in which Y first reads high.
  always_comb begin
    pulse_d = y_d && !y_q;
  end

  // Pulse register, cleared by reset.
  always_ff @(posedge CLK) begin
    if (!RN) pulse_q <= 1'b0;
    else     pulse_q <= pulse_d;
  end

  assign PULSE = pulse_q;
`endif

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp12t3v3__clkdiv_prog.sv
module tb_gf180mcu_osu_sc_gp12t3v3__clkdiv_prog;

  logic       CLK = 1'b0;
  logic       RN  = 1'b0;
  logic       EN  = 1'b0;
  logic       REQ = 1'b0;
  logic [3:0] DIV = 4'd0;
  logic       ACK, BUSY, Y;
`ifdef GF180_CLKDIV_PULSE_EN
  logic       PULSE;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: running/stopping flags, position in period, active ratio.
  bit   mdl_running;
  bit   mdl_stopping;
  int   mdl_pos;
  int   mdl_r;
  logic mdl_y, mdl_ack, mdl_busy, mdl_pulse;

  gf180mcu_osu_sc_gp12t3v3__clkdiv_prog #(.WIDTH(4), .DEFAULT_DIV(2)) dut (
    .CLK  (CLK),
    .RN   (RN),
    .EN   (EN),
    .DIV  (DIV),
    .REQ  (REQ),
    .ACK  (ACK),
    .BUSY (BUSY),
    .Y    (Y)
`ifdef GF180_CLKDIV_PULSE_EN
    ,
    .PULSE(PULSE)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One CLK edge of the reference model, expressed as period arithmetic.
  task automatic model_edge();
    int  new_r;
    bit  at_boundary;
    bit  prev_y;
    prev_y = mdl_y;
    if (!RN) begin
      mdl_running = 0; mdl_stopping = 0; mdl_pos = 0; mdl_r = 2;
      mdl_y = 0; mdl_ack = 0; mdl_busy = 0; mdl_pulse = 0;
      return;
    end
    at_boundary = !mdl_running || (mdl_pos == mdl_r - 1);
    new_r   = mdl_r;
    mdl_ack = 0;
    if (REQ && at_boundary) begin
      new_r   = (int'(DIV) < 2) ? 2 : int'(DIV);
      mdl_ack = 1;
    end
    if (!mdl_running) begin
      if (EN) begin mdl_running = 1; mdl_stopping = 0; mdl_pos = 0; end
    end else begin
      mdl_pos = (mdl_pos + 1) % mdl_r;
      if (!mdl_stopping) begin
        if (!EN) mdl_stopping = 1;
      end else if (EN) begin
        mdl_stopping = 0;
      end else if (mdl_pos == 0) begin
        mdl_running = 0; mdl_stopping = 0;
      end
    end
    mdl_r     = new_r;
    mdl_y     = mdl_running && (mdl_pos < (mdl_r + 1) / 2);
    mdl_busy  = mdl_running;
    mdl_pulse = mdl_y && !prev_y;
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    chk("Y", Y, mdl_y);
    chk("ACK", ACK, mdl_ack);
    chk("BUSY", BUSY, mdl_busy);
`ifdef GF180_CLKDIV_PULSE_EN
    chk("PULSE", PULSE, mdl_pulse);
`endif
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic count_highs(input int n, output int highs);
    highs = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (Y === 1'b1) highs++;
    end
  endtask

  task automatic req_div(input logic [3:0] d, output int lat);
    int got;
    REQ = 1'b1; DIV = d; lat = 0; got = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      lat++;
      if (ACK === 1'b1) begin got = 1; break; end
    end
    REQ = 1'b0;
    chk("ack_seen", got, 1);
  endtask

  task automatic wait_pos(input int p);
    int got;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      if (mdl_running && mdl_pos == p) begin got = 1; break; end
      step();
    end
    chk("wait_pos", got, 1);
  endtask

  initial begin
    int lat, highs;
    mdl_running = 0; mdl_stopping = 0; mdl_pos = 0; mdl_r = 2;
    mdl_y = 0; mdl_ack = 0; mdl_busy = 0; mdl_pulse = 0;

    // Reset held with EN and REQ asserted.
    RN = 0; EN = 1; REQ = 1; DIV = 4'd7;
    run(2);
    chk("rst_Y", Y, 0);
    chk("rst_ACK", ACK, 0);
    chk("rst_BUSY", BUSY, 0);

    // Release: Y rises one edge later, default period 2.
    RN = 1; REQ = 0;
    step();
    chk("start_Y", Y, 1);
    step();
    chk("def_period_low", Y, 0);
    count_highs(4, highs);
    chk("def_period_highs", highs, 2);

    // Even then odd ratio.
    req_div(4'd4, lat);
    chk("r4_first_level", Y, 1);
    count_highs(8, highs);
    chk("r4_highs", highs, 4);
    req_div(4'd5, lat);
    count_highs(10, highs);
    chk("r5_highs", highs, 6);

    // Mid-period change: request at position 1 of R=6 waits for the wrap.
    req_div(4'd6, lat);
    run(3);
    wait_pos(1);
    req_div(4'd3, lat);
    chk("midper_lat", lat, 5);
    count_highs(6, highs);
    chk("r3_highs", highs, 4);

    // Clamp and maximum ratio.
    req_div(4'd0, lat);
    count_highs(6, highs);
    chk("div0_highs", highs, 3);
    req_div(4'd1, lat);
    count_highs(6, highs);
    chk("div1_highs", highs, 3);
    req_div(4'd15, lat);
    count_highs(15, highs);
    chk("div15_highs", highs, 8);
    run(20);

    // Stop at position 1 of R=4: the period completes, then idle.
    req_div(4'd4, lat);
    wait_pos(1);
    EN = 0;
    run(3);
    chk("stop_Y", Y, 0);
    chk("stop_BUSY", BUSY, 0);
    run(3);

    // EN and REQ together in idle: capture and start on the same edge.
    EN = 1;
    req_div(4'd8, lat);
    chk("idle_req_lat", lat, 1);
    chk("idle_req_Y", Y, 1);
    wait_pos(2);
    EN = 0;
    step();
    EN = 1;
    step();
    chk("resume_BUSY", BUSY, 1);
    run(10);

    // Reset mid-run with a pending request.
    wait_pos(2);
    REQ = 1; DIV = 4'd5; RN = 0;
    step();
    chk("midrst_ACK", ACK, 0);
    chk("midrst_Y", Y, 0);
    RN = 1; REQ = 0;
    step();
    count_highs(4, highs);
    chk("midrst_r2_highs", highs, 2);

    // Randomized run with handshake, stop/resume, cancels and rare resets.
    for (int i = 0; i < 1500; i++) begin
      step();
      RN = ($urandom_range(199) != 0);
      if ($urandom_range(19) == 0) EN = ~EN;
      if (REQ) begin
        if (ACK === 1'b1 || $urandom_range(39) == 0) REQ = 1'b0;
      end else if ($urandom_range(14) == 0) begin
        REQ = 1'b1;
        DIV = 4'($urandom_range(15));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
